// File: rtl/if_fetch.sv
// Purpose : instruction fetch over an 8-bit memory port; four byte reads assemble one
//           little-endian 32-bit instruction, which is presented to ID.
// Latency : B0 entry to inst_valid_o is 5 cycles; one instruction per 6 cycles unstalled.
// Backpr. : stall_i holds the presented instruction in HOLD; it is ignored while fetching.
// Ports   : clk/rst (sync, active-low); stall_i, branch_flag_i/branch_addr_i from ID;
//           mem_a_o/mem_rd_o/mem_din_i byte memory port (data returns one cycle after the address);
//           pc_o/inst_o/inst_valid_o instruction presented to ID.
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_addr_i,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] mem_a_o,
  output logic        mem_rd_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [2:0] {
    S_B0   = 3'd0,
    S_B1   = 3'd1,
    S_B2   = 3'd2,
    S_B3   = 3'd3,
    S_WAIT = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] addr_off;
  logic        reading;

  // Redirect targets are word-aligned; the low two address bits are dropped.
  logic unused_branch_lsbs;
  assign unused_branch_lsbs = ^branch_addr_i[1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inst_d     = inst_q;
    if (branch_flag_i) begin
      // A redirect beats both stall and acceptance; partial bytes are simply refetched.
      state_d    = S_B0;
      fetch_pc_d = {branch_addr_i[31:2], 2'b00};
    end else begin
      // Each capture stores the byte addressed in the previous state.
      case (state_q)
        S_B0:   state_d = S_B1;
        S_B1: begin
          inst_d[7:0] = mem_din_i;
          state_d     = S_B2;
        end
        S_B2: begin
          inst_d[15:8] = mem_din_i;
          state_d      = S_B3;
        end
        S_B3: begin
          inst_d[23:16] = mem_din_i;
          state_d       = S_WAIT;
        end
        S_WAIT: begin
          inst_d[31:24] = mem_din_i;
          state_d       = S_HOLD;
        end
        S_HOLD: begin
          if (!stall_i) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_B0;
          end
        end
        default: state_d = S_B0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_B0;
      fetch_pc_q <= 32'h0;
      inst_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inst_q     <= inst_d;
    end
  end

  always_comb begin
    addr_off = 32'd0;
    case (state_q)
      S_B1:    addr_off = 32'd1;
      S_B2:    addr_off = 32'd2;
      S_B3:    addr_off = 32'd3;
      default: addr_off = 32'd0;
    endcase
  end

  assign reading = (state_q == S_B0) || (state_q == S_B1) ||
                   (state_q == S_B2) || (state_q == S_B3);

  // Every output is forced to zero while reset is held, whatever state the regs carry.
  assign mem_rd_o     = rst && reading;
  assign mem_a_o      = rst ? (fetch_pc_q + addr_off) : 32'h0;
  assign pc_o         = rst ? fetch_pc_q : 32'h0;
  assign inst_o       = rst ? inst_q : 32'h0;
  assign inst_valid_o = rst && (state_q == S_HOLD) && !branch_flag_i;

endmodule
